params_check: RTL and testbench

Runtime checker for the parameter-passing fake. It receives the six status outputs of a parameterized instance, waits for them to settle, and samples them over a stability window. It reports pass/fail with a per-field mismatch mask and an LED blink pattern, so a tool flow can prove on hardware that generics/parameters reached the design. It sits in the same fake top level, beside the parameterized instance it observes.

---
 rtl/params_check.sv | 116 +++++++++++
 tb/tb_params_check.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/params_check.sv
// Runtime checker for the parameter-passing fake: lets the observed instance settle,
// samples its six status fields over a stability window, then reports PASS/FAIL and blinks an LED.
module params_check #(
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned STABLE     = 16,
  parameter int unsigned EXP_INT    = 255,
  parameter logic [7:0]  EXP_VEC    = 8'hFF,
  parameter int unsigned BLINK_PASS = 24,
  parameter int unsigned BLINK_FAIL = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       boo_i,
  input  logic [7:0] int_i,
  input  logic       log_i,
  input  logic [7:0] vec_i,
  input  logic       str_i,
  input  logic       rea_i,
  input  logic       restart_i,
  output logic       done_o,
  output logic       pass_o,
  output logic [5:0] fail_mask_o,
  output logic       led_o
);

  localparam int unsigned PHASE_MAX = (SETTLE > STABLE) ? SETTLE : STABLE;
  localparam int unsigned CW        = $clog2(PHASE_MAX + 1);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_CHECK,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         phase_q, phase_d;
  logic [5:0]            mask_q, mask_d;
  logic [5:0]            mism;
  logic [BLINK_PASS-1:0] blink_q, blink_d;
  logic                  led_d;

  // Bit order matches fail_mask_o: [0]boo [1]int [2]log [3]vec [4]str [5]rea
  assign mism = {rea_i != 1'b1,
                 str_i != 1'b1,
                 vec_i != EXP_VEC,
                 log_i != 1'b1,
                 int_i != 8'(EXP_INT),
                 boo_i != 1'b1};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mask_d  = mask_q;
    blink_d = blink_q + BLINK_PASS'(1);
    if (restart_i) begin
      state_d = ST_SETTLE;
      phase_d = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (phase_q == CW'(SETTLE - 1)) begin
            state_d = ST_CHECK;
            phase_d = '0;
          end else begin
            phase_d = phase_q + CW'(1);
          end
        end
        ST_CHECK: begin
          mask_d = mask_q | mism;
          // Verdict uses the updated mask so the final sample counts.
          if (phase_q == CW'(STABLE - 1)) begin
            state_d = (mask_d == '0) ? ST_PASS : ST_FAIL;
            phase_d = '0;
          end else begin
            phase_d = phase_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led_d = 1'b0;
    case (state_d)
      ST_PASS: led_d = blink_d[BLINK_PASS-1];
      ST_FAIL: led_d = blink_d[BLINK_FAIL-1];
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_SETTLE;
      phase_q <= '0;
      mask_q  <= '0;
      blink_q <= '0;
      done_o  <= 1'b0;
      pass_o  <= 1'b0;
      led_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      blink_q <= blink_d;
      done_o  <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_o  <= (state_d == ST_PASS);
      led_o   <= led_d;
    end
  end

  assign fail_mask_o = mask_q;

endmodule

// File: tb/tb_params_check.sv
// Self-checking bench for params_check: scenario tasks push expected verdicts to a
// scoreboard queue and pop them when done_o rises.
module tb_params_check;

  localparam int unsigned SETTLE     = 4;
  localparam int unsigned STABLE     = 16;
  localparam int unsigned BLINK_PASS = 4;
  localparam int unsigned BLINK_FAIL = 2;
  localparam int          LAT        = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boo, log_v, str, rea, restart;
  logic [7:0] int_v, vec;
  logic       done, pass, led;
  logic [5:0] mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       pass;
    bit [5:0] mask;
    int       lat;
  } exp_t;
  exp_t exp_q[$];

  int unsigned ref_cnt;
  logic [5:0]  mask_hist [0:63];
  logic        led_hist  [0:63];
  int unsigned cnt_hist  [0:63];
  bit          done_seen;
  int          obs_lat;
  logic        obs_pass;
  logic [5:0]  obs_mask;

  params_check #(
    .SETTLE(SETTLE),
    .STABLE(STABLE),
    .EXP_INT(255),
    .EXP_VEC(8'hFF),
    .BLINK_PASS(BLINK_PASS),
    .BLINK_FAIL(BLINK_FAIL)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .boo_i(boo),
    .int_i(int_v),
    .log_i(log_v),
    .vec_i(vec),
    .str_i(str),
    .rea_i(rea),
    .restart_i(restart),
    .done_o(done),
    .pass_o(pass),
    .fail_mask_o(mask),
    .led_o(led)
  );

  always #5 clk = ~clk;

  // Reference free-running cycle count since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ref_cnt <= 0;
    else        ref_cnt <= ref_cnt + 1;

  task automatic drive_inputs(input logic [5:0] bad);
    boo   = !bad[0];
    int_v = bad[1] ? 8'd254 : 8'd255;
    log_v = !bad[2];
    vec   = bad[3] ? 8'h7F : 8'hFF;
    str   = !bad[4];
    rea   = !bad[5];
  endtask

  // Edge e (1-based) samples inputs driven in iteration e; stops at done or max_e.
  task automatic run_window(input logic [5:0] bad, input int from_e, input int to_e,
                            input int restart_e, input int max_e);
    done_seen = 0;
    obs_lat   = 0;
    for (int e = 1; e <= max_e; e++) begin
      drive_inputs((e >= from_e && e <= to_e) ? bad : 6'b0);
      restart = (e == restart_e);
      @(posedge clk); #1;
      mask_hist[e] = mask;
      if (done === 1'b1) begin
        done_seen = 1;
        obs_lat   = e;
        obs_pass  = pass;
        obs_mask  = mask;
        break;
      end
    end
    drive_inputs(6'b0);
    restart = 1'b0;
  endtask

  task automatic observe_led(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      led_hist[i] = led;
      cnt_hist[i] = ref_cnt;
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    restart = 1'b0;
    drive_inputs(6'b0);
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
    if (mask !== 6'b0) begin errors++; $display("FAIL reset_mask: got %b expected 000000", mask); end
    if (led  !== 1'b0) begin errors++; $display("FAIL reset_led: got %b expected 0", led); end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    exp_t ex;
    bit   bad_led;
    exp_q.push_back('{1'b1, 6'b0, LAT});
    run_window(6'b0, 0, -1, 0, 60);
    ex = exp_q.pop_front();
    checks += 4;
    if (!done_seen) begin errors++; $display("FAIL nominal_done: got no done expected done by edge %0d", ex.lat); end
    if (obs_lat != ex.lat) begin errors++; $display("FAIL nominal_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL nominal_pass: got %b expected %b", obs_pass, ex.pass); end
    if (obs_mask !== ex.mask) begin errors++; $display("FAIL nominal_mask: got %b expected %b", obs_mask, ex.mask); end
    observe_led(24);
    bad_led = 0;
    for (int i = 0; i < 24; i++)
      if (led_hist[i] !== cnt_hist[i][BLINK_PASS-1]) bad_led = 1;
    checks++;
    if (bad_led) begin errors++; $display("FAIL nominal_led: got %b expected %b", led_hist[0], cnt_hist[0][BLINK_PASS-1]); end
    drive_inputs(6'b111111);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pass !== 1'b1 || mask !== 6'b0) begin
      errors++; $display("FAIL post_done_glitch: got pass %b mask %b expected pass 1 mask 000000", pass, mask);
    end
    drive_inputs(6'b0);
  endtask

  task automatic test_glitch();
    exp_t ex;
    bit   bad_led;
    do_restart();
    exp_q.push_back('{1'b0, 6'b000010, LAT});
    run_window(6'b000010, SETTLE + 10, SETTLE + 10, 0, 60);
    ex = exp_q.pop_front();
    checks += 6;
    if (mask_hist[13] !== 6'b0) begin errors++; $display("FAIL glitch_mask_before: got %b expected 000000", mask_hist[13]); end
    if (mask_hist[14] !== 6'b000010) begin errors++; $display("FAIL glitch_mask_after: got %b expected 000010", mask_hist[14]); end
    if (!done_seen) begin errors++; $display("FAIL glitch_done: got no done expected done by edge %0d", ex.lat); end
    if (obs_lat != ex.lat) begin errors++; $display("FAIL glitch_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL glitch_pass: got %b expected %b", obs_pass, ex.pass); end
    if (obs_mask !== ex.mask) begin errors++; $display("FAIL glitch_mask: got %b expected %b", obs_mask, ex.mask); end
    observe_led(12);
    bad_led = 0;
    for (int i = 0; i < 12; i++)
      if (led_hist[i] !== cnt_hist[i][BLINK_FAIL-1]) bad_led = 1;
    checks++;
    if (bad_led) begin errors++; $display("FAIL glitch_led: got %b expected %b", led_hist[0], cnt_hist[0][BLINK_FAIL-1]); end
  endtask

  task automatic test_window_bounds();
    exp_t ex;
    do_restart();
    exp_q.push_back('{1'b1, 6'b0, LAT});
    run_window(6'b100000, 1, SETTLE, 0, 60);
    ex = exp_q.pop_front();
    checks += 3;
    if (obs_lat != ex.lat) begin errors++; $display("FAIL windowA_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL windowA_pass: got %b expected %b", obs_pass, ex.pass); end
    if (obs_mask !== ex.mask) begin errors++; $display("FAIL windowA_mask: got %b expected %b", obs_mask, ex.mask); end
    do_restart();
    exp_q.push_back('{1'b0, 6'b010000, LAT});
    run_window(6'b010000, LAT, LAT, 0, 60);
    ex = exp_q.pop_front();
    checks += 3;
    if (obs_lat != ex.lat) begin errors++; $display("FAIL windowB_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL windowB_pass: got %b expected %b", obs_pass, ex.pass); end
    if (obs_mask !== ex.mask) begin errors++; $display("FAIL windowB_mask: got %b expected %b", obs_mask, ex.mask); end
  endtask

  task automatic test_multi();
    exp_t ex;
    do_restart();
    exp_q.push_back('{1'b0, 6'b001001, LAT});
    run_window(6'b001001, 1, LAT, 0, 60);
    ex = exp_q.pop_front();
    checks += 5;
    if (mask_hist[SETTLE] !== 6'b0) begin errors++; $display("FAIL multi_settle_mask: got %b expected 000000", mask_hist[SETTLE]); end
    if (mask_hist[SETTLE+1] !== 6'b001001) begin errors++; $display("FAIL multi_first_mask: got %b expected 001001", mask_hist[SETTLE+1]); end
    if (obs_lat != ex.lat) begin errors++; $display("FAIL multi_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL multi_pass: got %b expected %b", obs_pass, ex.pass); end
    if (obs_mask !== ex.mask) begin errors++; $display("FAIL multi_mask: got %b expected %b", obs_mask, ex.mask); end
  endtask

  task automatic test_restart();
    exp_t ex;
    bit   held_bad;
    // A: restart out of FAIL with inputs already corrected
    restart = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mask !== 6'b0 || done !== 1'b0 || pass !== 1'b0 || led !== 1'b0) begin
      errors++; $display("FAIL restartA_clear: got mask %b done %b pass %b led %b expected all 0", mask, done, pass, led);
    end
    restart = 1'b0;
    exp_q.push_back('{1'b1, 6'b0, LAT});
    run_window(6'b0, 0, -1, 0, 60);
    ex = exp_q.pop_front();
    checks += 2;
    if (obs_lat != ex.lat) begin errors++; $display("FAIL restartA_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL restartA_pass: got %b expected %b", obs_pass, ex.pass); end
    // B: restart coincides with the final CHECK edge
    do_restart();
    run_window(6'b010000, 10, 10, LAT, LAT);
    checks += 3;
    if (done_seen) begin errors++; $display("FAIL restartB_done: got done at edge %0d expected none", obs_lat); end
    if (mask_hist[LAT-1] !== 6'b010000) begin errors++; $display("FAIL restartB_mask_pre: got %b expected 010000", mask_hist[LAT-1]); end
    if (mask_hist[LAT] !== 6'b0) begin errors++; $display("FAIL restartB_mask_post: got %b expected 000000", mask_hist[LAT]); end
    restart  = 1'b1;
    held_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || mask !== 6'b0) held_bad = 1;
    end
    checks++;
    if (held_bad) begin errors++; $display("FAIL restart_hold: got done %b mask %b expected 0 000000", done, mask); end
    restart = 1'b0;
    exp_q.push_back('{1'b1, 6'b0, LAT});
    run_window(6'b0, 0, -1, 0, 60);
    ex = exp_q.pop_front();
    checks += 2;
    if (obs_lat != ex.lat) begin errors++; $display("FAIL restartB_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL restartB_pass: got %b expected %b", obs_pass, ex.pass); end
  endtask

  task automatic test_async_reset();
    exp_t ex;
    do_restart();
    run_window(6'b000010, SETTLE + 2, SETTLE + 2, 0, 10);
    checks++;
    if (mask_hist[10] !== 6'b000010) begin errors++; $display("FAIL async_pre_mask: got %b expected 000010", mask_hist[10]); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mask !== 6'b0 || done !== 1'b0 || pass !== 1'b0 || led !== 1'b0) begin
      errors++; $display("FAIL async_reset_outputs: got mask %b done %b pass %b led %b expected all 0", mask, done, pass, led);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back('{1'b1, 6'b0, LAT});
    run_window(6'b0, 0, -1, 0, 60);
    ex = exp_q.pop_front();
    checks += 3;
    if (obs_lat != ex.lat) begin errors++; $display("FAIL async_latency: got %0d expected %0d", obs_lat, ex.lat); end
    if (obs_pass !== ex.pass) begin errors++; $display("FAIL async_pass: got %b expected %b", obs_pass, ex.pass); end
    if (obs_mask !== ex.mask) begin errors++; $display("FAIL async_mask: got %b expected %b", obs_mask, ex.mask); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_window_bounds();
    test_multi();
    test_restart();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
